// File: rtl/rasterizer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rasterizer_pkg
// Brief    : Shared types and constants for the depth-test / write-back stage
// Revision : 1.0
// ============================================================================
package rasterizer_pkg;

    typedef struct packed {
        logic [25:0] addr;
        logic [23:0] color;
        logic [31:0] old_depth;
        logic [31:0] new_depth;
    } frag_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_COLOR = 2'd1,
        WR_DEPTH = 2'd2
    } state_t;

    localparam logic [3:0]  BE_COLOR     = 4'b0111;
    localparam logic [3:0]  BE_DEPTH     = 4'b1111;
    localparam logic [25:0] DEPTH_OFFSET = 26'd4;

    // Smaller depth is closer; ties pass only when pass_equal is set.
    function automatic logic depth_test(input logic [31:0] new_depth,
                                        input logic [31:0] old_depth,
                                        input logic        pass_equal);
        return (new_depth < old_depth) || (pass_equal && (new_depth == old_depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rasterizer_frag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_frag_fifo
// Brief    : Show-ahead fragment buffer with full/empty/almost-full status
// Revision : 1.0
// ============================================================================
module rasterizer_frag_fifo
    import rasterizer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  frag_t                         push_data,
    input  logic                          pop,
    output frag_t                         head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          almost_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL_LEVEL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_AF_LEVEL   = CW'(FIFO_DEPTH - AF_MARGIN);

    frag_t           r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty       = (r_count == '0);
    assign full        = (r_count == C_FULL_LEVEL);
    assign almost_full = (r_count >= C_AF_LEVEL);
    assign count       = r_count;
    assign head        = r_mem[r_rd_ptr];

    // A simultaneous pop frees the slot, so a push is still taken when full.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rasterizer_depth_write.sv
`default_nettype none
// ============================================================================
// Module   : rasterizer_depth_write
// Brief    : Depth test on fetched fragments; writes colour+depth via Avalon-MM
// Revision : 1.0
// ============================================================================
module rasterizer_depth_write
    import rasterizer_pkg::*;
#(
    parameter int   FIFO_DEPTH = 16,
    parameter int   AF_MARGIN  = 4,
    parameter logic PASS_EQUAL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        input_valid,
    input  logic [25:0] addr_in,
    input  logic [23:0] color_in,
    input  logic [31:0] old_depth_in,
    input  logic [31:0] new_depth_in,
    output logic        wait_request,
    output logic [25:0] master_address,
    output logic        master_write,
    output logic        master_read,
    output logic [3:0]  master_byteenable,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest,
    output logic        busy,
    output logic [31:0] pass_count,
    output logic [31:0] fail_count,
    output logic        overflow
);

    frag_t                        w_in_frag;
    frag_t                        w_head;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_almost_full;
    logic [$clog2(FIFO_DEPTH):0]  w_count;
    logic                         w_head_pass;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         w_pop;
    logic                         w_fail_inc;
    logic                         w_pass_inc;

    logic [25:0]                  r_addr;
    logic [23:0]                  r_color;
    logic [31:0]                  r_new_depth;

    logic                         r_master_write;
    logic [25:0]                  r_master_address;
    logic [31:0]                  r_master_writedata;
    logic [3:0]                   r_master_byteenable;
    logic [31:0]                  r_pass_count;
    logic [31:0]                  r_fail_count;
    logic                         r_overflow;

    assign w_in_frag = '{addr: addr_in, color: color_in,
                         old_depth: old_depth_in, new_depth: new_depth_in};

    rasterizer_frag_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .AF_MARGIN  (AF_MARGIN)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (input_valid),
        .push_data   (w_in_frag),
        .pop         (w_pop),
        .head        (w_head),
        .full        (w_full),
        .empty       (w_empty),
        .count       (w_count),
        .almost_full (w_almost_full)
    );

    assign w_head_pass = depth_test(w_head.new_depth, w_head.old_depth, PASS_EQUAL);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // WR_COLOR only advances once the registered write strobe is actually on the bus.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_fail_inc   = 1'b0;
        w_pass_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_pass) begin
                        w_state_next = WR_COLOR;
                    end else begin
                        w_fail_inc = 1'b1;
                    end
                end
            end
            WR_COLOR: begin
                if (r_master_write && !master_waitrequest) begin
                    w_state_next = WR_DEPTH;
                end
            end
            WR_DEPTH: begin
                if (!master_waitrequest) begin
                    w_state_next = IDLE;
                    w_pass_inc   = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= '0;
            r_color     <= '0;
            r_new_depth <= '0;
        end else if (w_pop) begin
            r_addr      <= w_head.addr;
            r_color     <= w_head.color;
            r_new_depth <= w_head.new_depth;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_master_write      <= 1'b0;
            r_master_address    <= '0;
            r_master_writedata  <= '0;
            r_master_byteenable <= '0;
        end else begin
            case (r_state)
                WR_COLOR: begin
                    if (!r_master_write) begin
                        r_master_write      <= 1'b1;
                        r_master_address    <= r_addr;
                        r_master_writedata  <= {8'h00, r_color};
                        r_master_byteenable <= BE_COLOR;
                    end else if (!master_waitrequest) begin
                        r_master_address    <= r_addr + DEPTH_OFFSET;
                        r_master_writedata  <= r_new_depth;
                        r_master_byteenable <= BE_DEPTH;
                    end
                end
                WR_DEPTH: begin
                    if (!master_waitrequest) begin
                        r_master_write      <= 1'b0;
                        r_master_address    <= '0;
                        r_master_writedata  <= '0;
                        r_master_byteenable <= '0;
                    end
                end
                default: begin
                    r_master_write <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pass_count <= '0;
            r_fail_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_pass_inc) begin
                r_pass_count <= r_pass_count + 32'd1;
            end
            if (w_fail_inc) begin
                r_fail_count <= r_fail_count + 32'd1;
            end
            if (input_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wait_request      = w_almost_full;
    assign busy              = (w_count != '0) || (r_state != IDLE);
    assign master_write      = r_master_write;
    assign master_read       = 1'b0;
    assign master_address    = r_master_address;
    assign master_writedata  = r_master_writedata;
    assign master_byteenable = r_master_byteenable;
    assign pass_count        = r_pass_count;
    assign fail_count        = r_fail_count;
    assign overflow          = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rasterizer_depth_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_rasterizer_depth_write
// Brief    : Directed + random bench with a queue-based write model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rasterizer_depth_write;

    typedef struct packed {
        logic [25:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        input_valid;
    logic [25:0] addr_in;
    logic [23:0] color_in;
    logic [31:0] old_depth_in;
    logic [31:0] new_depth_in;
    logic        master_waitrequest;
    logic        eq_en;
    logic        rand_wr;

    logic        wait_request, master_write, master_read, busy, overflow;
    logic [25:0] master_address;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata, pass_count, fail_count;

    logic        eq_wait_request, eq_master_write, eq_master_read, eq_busy, eq_overflow;
    logic [25:0] eq_master_address;
    logic [3:0]  eq_master_byteenable;
    logic [31:0] eq_master_writedata, eq_pass_count, eq_fail_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_pass = 0, m_fail = 0, m_eq_pass = 0, m_eq_fail = 0;
    logic        m_overflow = 1'b0;
    wr_t         exp_q[$];
    wr_t         eq_q[$];
    wr_t         mon_e;

    always #5 clock = ~clock;

    rasterizer_depth_write dut (
        .clock(clock), .reset(reset), .input_valid(input_valid),
        .addr_in(addr_in), .color_in(color_in),
        .old_depth_in(old_depth_in), .new_depth_in(new_depth_in),
        .wait_request(wait_request), .master_address(master_address),
        .master_write(master_write), .master_read(master_read),
        .master_byteenable(master_byteenable), .master_writedata(master_writedata),
        .master_waitrequest(master_waitrequest), .busy(busy),
        .pass_count(pass_count), .fail_count(fail_count), .overflow(overflow)
    );

    rasterizer_depth_write #(.PASS_EQUAL(1'b1)) dut_eq (
        .clock(clock), .reset(reset), .input_valid(input_valid && eq_en),
        .addr_in(addr_in), .color_in(color_in),
        .old_depth_in(old_depth_in), .new_depth_in(new_depth_in),
        .wait_request(eq_wait_request), .master_address(eq_master_address),
        .master_write(eq_master_write), .master_read(eq_master_read),
        .master_byteenable(eq_master_byteenable), .master_writedata(eq_master_writedata),
        .master_waitrequest(1'b0), .busy(eq_busy),
        .pass_count(eq_pass_count), .fail_count(eq_fail_count), .overflow(eq_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_pass(input logic [31:0] nd, input logic [31:0] od, input bit pe);
        return (nd < od) || (pe && nd == od);
    endfunction

    function automatic logic [25:0] plus4(input logic [25:0] a);
        int unsigned t;
        t = (int'(a) + 4) % (1 << 26);
        return 26'(t);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [25:0] a, input logic [23:0] c,
                        input logic [31:0] od, input logic [31:0] nd, input bit acc);
        addr_in = a; color_in = c; old_depth_in = od; new_depth_in = nd;
        input_valid = 1'b1;
        if (acc) begin
            if (ref_pass(nd, od, 1'b0)) begin
                exp_q.push_back('{a, {8'h00, c}, 4'b0111});
                exp_q.push_back('{plus4(a), nd, 4'b1111});
                m_pass++;
            end else begin
                m_fail++;
            end
            if (eq_en) begin
                if (ref_pass(nd, od, 1'b1)) begin
                    eq_q.push_back('{a, {8'h00, c}, 4'b0111});
                    eq_q.push_back('{plus4(a), nd, 4'b1111});
                    m_eq_pass++;
                end else begin
                    m_eq_fail++;
                end
            end
        end
        tick();
        input_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy || master_write || eq_busy || eq_master_write) && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 64'(n < 3000), 64'(1));
    endtask

    task automatic wait_mw(input string tag);
        int n = 0;
        while (!master_write && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_mw_timeout"}, 64'(n < 50), 64'(1));
    endtask

    // Bus monitor: every accepted transfer is matched against the model queue.
    always @(negedge clock) begin
        if (!reset && master_write && !master_waitrequest) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(master_address), 64'(26'h3FFFFFF) + 64'(1));
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(master_address), 64'(mon_e.a));
                check("wr_data", 64'(master_writedata), 64'(mon_e.d));
                check("wr_be", 64'(master_byteenable), 64'(mon_e.be));
            end
        end
        if (!reset && eq_master_write) begin
            if (eq_q.size() == 0) begin
                check("eq_unexpected_write", 64'(eq_master_address), 64'(26'h3FFFFFF) + 64'(1));
            end else begin
                mon_e = eq_q.pop_front();
                check("eq_wr_addr", 64'(eq_master_address), 64'(mon_e.a));
                check("eq_wr_data", 64'(eq_master_writedata), 64'(mon_e.d));
                check("eq_wr_be", 64'(eq_master_byteenable), 64'(mon_e.be));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_wr) master_waitrequest = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ;
        bit popped;
        logic [25:0] hold_a;

        reset = 1'b1; input_valid = 1'b0; addr_in = '0; color_in = '0;
        old_depth_in = '0; new_depth_in = '0; master_waitrequest = 1'b0;
        eq_en = 1'b0; rand_wr = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_mw", 64'(master_write), 64'(0));
        check("rst_addr", 64'(master_address), 64'(0));
        check("rst_data", 64'(master_writedata), 64'(0));
        check("rst_be", 64'(master_byteenable), 64'(0));
        check("rst_pass", 64'(pass_count), 64'(0));
        check("rst_fail", 64'(fail_count), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_wreq", 64'(wait_request), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_read", 64'(master_read), 64'(0));
        reset = 1'b0;
        tick();

        // Single passing fragment, with latency
        send(26'h100, 24'hABCDEF, 32'h200, 32'h100, 1'b1);
        tick();
        check("lat_n1_mw", 64'(master_write), 64'(0));
        tick();
        check("lat_n2_mw", 64'(master_write), 64'(1));
        check("lat_n2_addr", 64'(master_address), 64'(26'h100));
        drain("single");
        check("single_pass", 64'(pass_count), 64'(1));
        check("single_q", 64'(exp_q.size()), 64'(0));

        // Equal depths: fail on default instance, pass on PASS_EQUAL instance
        eq_en = 1'b1;
        send(26'h200, 24'h123456, 32'h50, 32'h50, 1'b1);
        send(26'h208, 24'h654321, 32'h50, 32'h51, 1'b1);
        eq_en = 1'b0;
        drain("equal");
        check("eq_main_fail", 64'(fail_count), 64'(m_fail));
        check("eq_main_pass", 64'(pass_count), 64'(m_pass));
        check("eq_inst_pass", 64'(eq_pass_count), 64'(m_eq_pass));
        check("eq_inst_fail", 64'(eq_fail_count), 64'(m_eq_fail));
        check("eq_inst_q", 64'(eq_q.size()), 64'(0));
        check("eq_inst_ovf", 64'(eq_overflow), 64'(0));
        check("eq_inst_wreq", 64'(eq_wait_request), 64'(0));
        check("eq_inst_read", 64'(eq_master_read), 64'(0));

        // Waitrequest held during colour write
        master_waitrequest = 1'b1;
        send(26'h345, 24'h0F0F0F, 32'hFFFF, 32'h10, 1'b1);
        wait_mw("hold");
        for (int i = 0; i < 5; i++) begin
            check("hold_mw", 64'(master_write), 64'(1));
            check("hold_addr", 64'(master_address), 64'(26'h345));
            check("hold_data", 64'(master_writedata), 64'(32'h000F0F0F));
            check("hold_be", 64'(master_byteenable), 64'(4'b0111));
            tick();
        end
        master_waitrequest = 1'b0;
        drain("hold");
        check("hold_pass", 64'(pass_count), 64'(m_pass));

        // Back-to-back burst with the bus stalled: almost-full and overflow
        master_waitrequest = 1'b1;
        occ = 0;
        popped = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bit pop_now;
            bit acc;
            pop_now = !popped && occ > 0;
            acc = (occ < 16) || pop_now;
            send(26'h1000 + 26'(k * 8), 24'(k), 32'h1000, 32'(k), acc);
            if (pop_now) begin
                occ--;
                popped = 1'b1;
            end
            if (acc) occ++;
            else m_overflow = 1'b1;
            check("af_wait_request", 64'(wait_request), 64'(occ >= 12));
            check("af_overflow", 64'(overflow), 64'(m_overflow));
        end
        master_waitrequest = 1'b0;
        drain("burst");
        check("burst_pass", 64'(pass_count), 64'(m_pass));
        check("burst_q", 64'(exp_q.size()), 64'(0));
        check("burst_ovf_sticky", 64'(overflow), 64'(1));

        // 26-bit address wrap on the depth word
        send(26'h3FFFFFC, 24'h00FF00, 32'h80000000, 32'h1, 1'b1);
        drain("wrap");
        check("wrap_pass", 64'(pass_count), 64'(m_pass));

        // Random traffic, honouring wait_request, random bus stalls
        rand_wr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int n;
            logic [31:0] od;
            logic [31:0] nd;
            repeat ($urandom_range(0, 3)) tick();
            n = 0;
            while (wait_request && n < 500) begin
                tick();
                n++;
            end
            check("rand_wreq_timeout", 64'(n < 500), 64'(1));
            od = $urandom;
            case ($urandom_range(0, 3))
                0:       nd = od;
                1:       nd = od >> $urandom_range(0, 8);
                default: nd = $urandom;
            endcase
            send(26'($urandom), 24'($urandom), od, nd, 1'b1);
        end
        rand_wr = 1'b0;
        master_waitrequest = 1'b0;
        drain("rand");
        check("rand_pass", 64'(pass_count), 64'(m_pass));
        check("rand_fail", 64'(fail_count), 64'(m_fail));
        check("rand_q", 64'(exp_q.size()), 64'(0));

        // Reset while the depth word is on the bus
        master_waitrequest = 1'b1;
        send(26'h2A0, 24'h445566, 32'h9000, 32'h10, 1'b1);
        for (int i = 0; i < 3; i++) send(26'h300 + 26'(i * 8), 24'(i), 32'h9000, 32'h20, 1'b1);
        wait_mw("rst");
        master_waitrequest = 1'b0;
        tick();
        master_waitrequest = 1'b1;
        hold_a = master_address;
        check("rst_in_depth_addr", 64'(hold_a), 64'(26'h2A4));
        check("rst_in_depth_mw", 64'(master_write), 64'(1));
        reset = 1'b1;
        tick();
        exp_q.delete();
        m_pass = 0;
        m_fail = 0;
        check("midrst_mw", 64'(master_write), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_pass", 64'(pass_count), 64'(m_pass));
        check("midrst_fail", 64'(fail_count), 64'(m_fail));
        check("midrst_ovf", 64'(overflow), 64'(0));
        check("midrst_wreq", 64'(wait_request), 64'(0));
        reset = 1'b0;
        master_waitrequest = 1'b0;
        tick();
        tick();
        check("postrst_busy", 64'(busy), 64'(0));
        check("postrst_mw", 64'(master_write), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
